// File: rtl/if_id_pkg.sv
// ----------------------------------------------------------------------------
// if_id_pkg
// Shared definitions for the fetch/decode boundary queue.
//   XLEN          : datapath width (32)
//   NOP_INSTR     : instruction presented to decode when the queue is empty
//                   (addi x0, x0, 0)
//   if_id_entry_t : one queued entry, {pc, instr}
//   is_pow2()     : elaboration-time helper used to validate queue depth
// ----------------------------------------------------------------------------
package if_id_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_entry_t;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// ----------------------------------------------------------------------------
// if_id_queue_if
// Handshake bundle between the fetch stage, the IF/ID queue and decode.
//   Fetch side  : in_valid, in_pc, in_instr, in_qed_instr, in_qed_vld -> queue
//                 in_ready                                       <- queue
//   Decode side : out_valid, out_pc, out_instr                   <- queue
//                 out_ready                                      -> queue
// Modports:
//   slave  : the queue itself
//   master : the surrounding pipeline (fetch producer + decode consumer)
// ----------------------------------------------------------------------------
interface if_id_queue_if;
    import if_id_pkg::*;

    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_qed_instr;
    logic            in_qed_vld;
    logic            in_ready;

    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_ready;

    modport slave (
        input  in_valid,
        input  in_pc,
        input  in_instr,
        input  in_qed_instr,
        input  in_qed_vld,
        output in_ready,
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_pc,
        output in_instr,
        output in_qed_instr,
        output in_qed_vld,
        input  in_ready,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready
    );

endinterface

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
// Small circular FIFO sitting between instruction fetch and decode.
// Entries are {pc, instr}. No bypass: a pushed entry reaches the head on the
// following cycle at the earliest. Flush (taken branch) empties the queue;
// reset does the same and outranks flush, push and pop.
//
// Ports:
//   clk    : clock, all state changes on rising edge
//   reset  : synchronous, active-high
//   flush  : discard all entries at the next edge
//   bus    : if_id_queue_if.slave handshake bundle (fetch in, decode out)
//   count  : current occupancy, 0..DEPTH
//
// Parameters:
//   DEPTH     : number of entries, power of two, >= 2
//   NOP_INSTR : instruction presented on out_instr while empty
//
// Build option:
//   QED_QUEUE_EN : when defined, pushes additionally require in_qed_vld and the
//                  stored instruction is in_qed_instr instead of in_instr.
//                  When undefined, both QED inputs are ignored.
// ----------------------------------------------------------------------------
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int unsigned     DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = if_id_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    if_id_queue_if.slave           bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("if_id_queue: DEPTH must be a power of two and at least 2");
    end

    if_id_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    logic             push_en;
    logic             push;
    logic             pop;
    if_id_entry_t     wr_entry;
    if_id_entry_t     head;

`ifdef QED_QUEUE_EN
    assign push_en  = bus.in_valid & bus.in_qed_vld;
    assign wr_entry = '{pc: bus.in_pc, instr: bus.in_qed_instr};
`else
    assign push_en  = bus.in_valid;
    assign wr_entry = '{pc: bus.in_pc, instr: bus.in_instr};

    // QED inputs exist on the bundle but carry no meaning in this build.
    logic qed_unused;
    assign qed_unused = ^{bus.in_qed_instr, bus.in_qed_vld};
`endif

    // in_ready is forced low during reset so fetch never advances its PC
    // on an entry that reset is about to throw away.
    assign bus.in_ready  = (count_q != FULL_CNT) && !reset;
    assign bus.out_valid = (count_q != '0);

    assign push = push_en & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Pointers are PTR_W bits wide, so wrap modulo DEPTH is implicit.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    // push already excludes reset through in_ready; flush must block it here.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        bus.out_pc    = '0;
        bus.out_instr = NOP_INSTR;
        if (bus.out_valid) begin
            bus.out_pc    = head.pc;
            bus.out_instr = head.instr;
        end
    end

    assign count = count_q;

endmodule
